// File: rtl/player_motion_controller_pkg.sv
// Shared constants and types for the player motion controller slice.
package player_motion_controller_pkg;

  // Video coordinate width and playfield geometry
  localparam int CORDW    = 10;
  localparam int PLAYER_W = 16;
  localparam int PLAYER_Y = 448;
  localparam int H_RES    = 640;
  localparam int V_RES    = 480;

  // Datapath widths: player_x, its widened arithmetic form, cooldown counter
  localparam int XW  = 10;
  localparam int XAW = 11;
  localparam int CDW = 8;

  // Fire handshake states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_COOLDOWN = 2'd2
  } fire_state_e;

endpackage

// File: rtl/player_motion_controller_button_sync.sv
// Two-flop synchroniser for one raw button, with a one-cycle rising-edge pulse
// derived from the synchronised level.
module player_motion_controller_button_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchroniser chain plus a delayed copy of the clean level for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/player_motion_controller.sv
// Player motion controller: synchronises the buttons, produces a once-per-frame
// tick at the start of vertical blanking, moves player_x on that tick with
// clamping, and runs the fire request / cooldown handshake.
module player_motion_controller
  import player_motion_controller_pkg::*;
#(
  parameter int V_RES_P       = V_RES,
  parameter int STEP          = 2,
  parameter int X_MIN         = 8,
  parameter int X_MAX         = 624 - PLAYER_W,
  parameter int X_RESET       = 320,
  parameter int FIRE_COOLDOWN = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_fire,
  input  logic [CORDW-1:0] pixel,
  input  logic [CORDW-1:0] line,
  input  logic             enable,
  input  logic             shot_busy,
  input  logic             fire_ack,
  output logic [XW-1:0]    player_x,
  output logic             fire_req,
  output logic             frame_tick
);

  localparam logic [CORDW-1:0]      LP_VRES   = CORDW'(V_RES_P);
  localparam logic signed [XAW-1:0] LP_STEP   = XAW'(STEP);
  localparam logic signed [XAW-1:0] LP_XMIN   = XAW'(X_MIN);
  localparam logic signed [XAW-1:0] LP_XMAX   = XAW'(X_MAX);
  localparam logic [XW-1:0]         LP_XRESET = XW'(X_RESET);
  localparam logic [CDW-1:0]        LP_COOL   = CDW'(FIRE_COOLDOWN);

  // Clamp a widened candidate position into the legal range before truncation,
  // so stepping past either end can never wrap.
  function automatic logic [XW-1:0] clamp_x(input logic signed [XAW-1:0] v);
    if (v < LP_XMIN)      clamp_x = LP_XMIN[XW-1:0];
    else if (v > LP_XMAX) clamp_x = LP_XMAX[XW-1:0];
    else                  clamp_x = v[XW-1:0];
  endfunction

  logic w_left;
  logic w_right;
  logic w_fire;
  logic w_fire_rise;
  logic w_left_rise_unused;
  logic w_right_rise_unused;

  logic r_frame_tick;
  logic [XW-1:0] r_x;
  logic [XW-1:0] w_x_nxt;
  logic signed [XAW-1:0] w_x_ext;
  logic signed [XAW-1:0] w_x_dec;
  logic signed [XAW-1:0] w_x_inc;

  fire_state_e r_state;
  fire_state_e w_state_nxt;
  logic [CDW-1:0] r_cool;
  logic [CDW-1:0] w_cool_nxt;

  player_motion_controller_button_sync u_sync_left (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_left),
    .o_level (w_left),
    .o_rise  (w_left_rise_unused)
  );

  player_motion_controller_button_sync u_sync_right (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_right),
    .o_level (w_right),
    .o_rise  (w_right_rise_unused)
  );

  player_motion_controller_button_sync u_sync_fire (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_fire),
    .o_level (w_fire),
    .o_rise  (w_fire_rise)
  );

  // Frame tick: one registered pulse after the first pixel of the first blanking line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_frame_tick <= 1'b0;
    else     r_frame_tick <= (line == LP_VRES) && (pixel == '0);
  end

  assign w_x_ext = signed'({1'b0, r_x});
  assign w_x_dec = w_x_ext - LP_STEP;
  assign w_x_inc = w_x_ext + LP_STEP;

  // Next position: move only on an enabled frame tick with exactly one direction held
  always_comb begin
    w_x_nxt = r_x;
    if (r_frame_tick && enable) begin
      if (w_left && !w_right)      w_x_nxt = clamp_x(w_x_dec);
      else if (w_right && !w_left) w_x_nxt = clamp_x(w_x_inc);
    end
  end

  // Player position register; stable between frame ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_x <= LP_XRESET;
    else     r_x <= w_x_nxt;
  end

  // Fire FSM state and cooldown counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cool  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cool  <= w_cool_nxt;
    end
  end

  // Fire FSM next state; dropping enable overrides everything, including an ack
  always_comb begin
    w_state_nxt = r_state;
    w_cool_nxt  = r_cool;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_cool_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire_rise && !shot_busy) w_state_nxt = ST_REQ;
        end
        ST_REQ: begin
          if (fire_ack) begin
            w_state_nxt = ST_COOLDOWN;
            w_cool_nxt  = LP_COOL;
          end
        end
        ST_COOLDOWN: begin
          if (r_frame_tick) begin
            if (r_cool <= 8'd1) begin
              w_state_nxt = ST_IDLE;
              w_cool_nxt  = '0;
            end else begin
              w_cool_nxt = r_cool - 8'd1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cool_nxt  = '0;
        end
      endcase
    end
  end

  assign player_x   = r_x;
  assign fire_req   = (r_state == ST_REQ);
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_player_motion_controller.sv
// Bench for player_motion_controller: shortened video timing, table-driven
// movement vectors through a scoreboard queue, hand-written fire sequences.
module tb_player_motion_controller;

  logic       clk;
  logic       rst;
  logic       btn_left;
  logic       btn_right;
  logic       btn_fire;
  logic [9:0] pixel;
  logic [9:0] line;
  logic       enable;
  logic       shot_busy;
  logic       fire_ack;
  logic [9:0] player_x;
  logic       fire_req;
  logic       frame_tick;

  int total;
  int bad;
  int midframe_bad;
  logic mon_en;
  logic [9:0] prev_x;
  logic prev_tick;

  typedef struct {
    logic       l;
    logic       r;
    logic       en;
    int         n;
    logic [9:0] exp;
    string      name;
  } mv_t;

  mv_t vec[11];
  logic [9:0] sb_q[$];

  player_motion_controller dut (
    .clk        (clk),
    .rst        (rst),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_fire   (btn_fire),
    .pixel      (pixel),
    .line       (line),
    .enable     (enable),
    .shot_busy  (shot_busy),
    .fire_ack   (fire_ack),
    .player_x   (player_x),
    .fire_req   (fire_req),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Short frame: lines 479..481, pixels 0..7, so line 480 pixel 0 occurs once per 24 clk
  initial begin
    pixel = 10'd0;
    line  = 10'd479;
    forever begin
      @(negedge clk);
      if (pixel == 10'd7) begin
        pixel = 10'd0;
        line  = (line == 10'd481) ? 10'd479 : line + 10'd1;
      end else begin
        pixel = pixel + 10'd1;
      end
    end
  end

  // Position may only change on the cycle following a frame tick
  initial begin
    midframe_bad = 0;
    prev_x = 10'd0;
    prev_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && (player_x != prev_x) && !prev_tick) midframe_bad = midframe_bad + 1;
      prev_x = player_x;
      prev_tick = frame_tick;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_tick();
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c = c + 1;
    end while (!frame_tick && c < 100);
    if (!frame_tick) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL tick_timeout: got no frame_tick within %0d clk expected one", c);
    end
  endtask

  task automatic wait_req(input int maxc, output logic got);
    got = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (fire_req) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic press_expect(input string nm, input logic exp_req);
    logic got;
    btn_fire = 1'b1;
    wait_req(3, got);
    if (exp_req) begin
      chk(nm, got, 1'b1);
    end else begin
      repeat (3) @(negedge clk);
      chk(nm, fire_req, 1'b0);
    end
    btn_fire = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int ticks;
    logic got;
    total = 0;
    bad = 0;
    mon_en = 1'b0;
    rst = 1'b1;
    btn_left = 1'b1;
    btn_right = 1'b1;
    btn_fire = 1'b1;
    enable = 1'b1;
    shot_busy = 1'b0;
    fire_ack = 1'b0;

    vec[0]  = '{1'b0, 1'b1, 1'b1, 10,  10'd340, "right_x10"};
    vec[1]  = '{1'b1, 1'b1, 1'b1, 3,   10'd340, "both_hold"};
    vec[2]  = '{1'b0, 1'b0, 1'b1, 2,   10'd340, "none_hold"};
    vec[3]  = '{1'b1, 1'b0, 1'b1, 164, 10'd12,  "left_to_12"};
    vec[4]  = '{1'b1, 1'b0, 1'b1, 1,   10'd10,  "left_10"};
    vec[5]  = '{1'b1, 1'b0, 1'b1, 1,   10'd8,   "left_8"};
    vec[6]  = '{1'b1, 1'b0, 1'b1, 1,   10'd8,   "left_clamp_min"};
    vec[7]  = '{1'b0, 1'b1, 1'b0, 3,   10'd8,   "right_disabled"};
    vec[8]  = '{1'b0, 1'b1, 1'b1, 310, 10'd608, "right_clamp_max"};
    vec[9]  = '{1'b0, 1'b1, 1'b1, 1,   10'd608, "right_stay_max"};
    vec[10] = '{1'b1, 1'b0, 1'b1, 2,   10'd604, "left_from_max"};

    // Reset held with every button pressed: outputs at reset values, no ticks
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (frame_tick) ticks = ticks + 1;
    end
    chk("rst_x", player_x, 10'd320);
    chk("rst_fire_req", fire_req, 1'b0);
    chk("rst_tick_count", ticks, 0);
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_fire = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Exactly one single-cycle tick per 24-clk frame
    ticks = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (frame_tick) ticks = ticks + 1;
    end
    chk("tick_per_frame", ticks, 2);
    chk("x_idle", player_x, 10'd320);

    // Movement table, expectations queued and popped after each run of ticks
    wait_tick();
    prev_x = player_x;
    mon_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      btn_left = vec[i].l;
      btn_right = vec[i].r;
      enable = vec[i].en;
      sb_q.push_back(vec[i].exp);
      for (int k = 0; k < vec[i].n; k++) wait_tick();
      @(negedge clk);
      chk(vec[i].name, player_x, sb_q.pop_front());
    end
    mon_en = 1'b0;
    chk("midframe_stable", midframe_bad, 0);
    btn_left = 1'b0;
    btn_right = 1'b0;
    enable = 1'b1;
    repeat (4) @(negedge clk);

    // Basic request and handshake
    btn_fire = 1'b1;
    wait_req(3, got);
    chk("req_latency", got, 1'b1);
    btn_fire = 1'b0;
    repeat (5) @(negedge clk);
    chk("req_held", fire_req, 1'b1);
    wait_tick();
    fire_ack = 1'b1;
    @(negedge clk);
    fire_ack = 1'b0;
    chk("req_clear", fire_req, 1'b0);

    // Cooldown: presses on tick 1 and tick 29 are dropped, press after tick 30 accepted
    wait_tick();
    press_expect("cool_block_early", 1'b0);
    for (int k = 0; k < 28; k++) wait_tick();
    press_expect("cool_block_29", 1'b0);
    wait_tick();
    press_expect("req_after_cool", 1'b1);
    wait_tick();
    fire_ack = 1'b1;
    @(negedge clk);
    fire_ack = 1'b0;

    // Dropping enable clears cooldown; shot_busy blocks the request
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    shot_busy = 1'b1;
    press_expect("busy_block", 1'b0);
    shot_busy = 1'b0;
    press_expect("req_after_busy", 1'b1);

    // Enable dropped in REQ: request withdrawn next clk, movement frozen
    btn_right = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("en_drop_req", fire_req, 1'b0);
    wait_tick();
    wait_tick();
    @(negedge clk);
    chk("en_drop_hold_x", player_x, 10'd604);
    btn_right = 1'b0;
    repeat (4) @(negedge clk);
    enable = 1'b1;

    // Stray ack in IDLE is ignored, then ack coinciding with enable drop leaves no cooldown
    fire_ack = 1'b1;
    @(negedge clk);
    fire_ack = 1'b0;
    press_expect("req_after_stray_ack", 1'b1);
    fire_ack = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    fire_ack = 1'b0;
    enable = 1'b1;
    chk("ack_en_same", fire_req, 1'b0);
    press_expect("req_after_ack_en", 1'b1);

    // Asynchronous reset in REQ
    rst = 1'b1;
    #1;
    chk("rst_req_async", fire_req, 1'b0);
    chk("rst_x_async", player_x, 10'd320);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    press_expect("req_after_rst", 1'b1);

    // Asynchronous reset in COOLDOWN
    wait_tick();
    fire_ack = 1'b1;
    @(negedge clk);
    fire_ack = 1'b0;
    wait_tick();
    rst = 1'b1;
    #1;
    chk("rst_cool_async", fire_req, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    press_expect("req_after_rst_cool", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
